// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle for rr_grant_arbiter.
// The master side drives requests and release; the slave side (the arbiter) returns the grant.
interface rr_grant_arbiter_if #(
    parameter int WIDTH = 16
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] req;
    logic             done;
    logic [WIDTH-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_idx,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with hold-until-release ownership.
// One owner at a time; on release the pointer moves past the owner and the next
// winner (if any) is granted back-to-back.
// Optional hold-time limit: define RR_ARB_TIMEOUT_EN to force a release after
// TIMEOUT cycles of continuous ownership and pulse timeout.
module rr_grant_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    rr_grant_arbiter_if.slave   bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE_HOT0 = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {ST_IDLE, ST_OWNED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic             release_w;
    logic             hold_expired;
    logic [IDX_W-1:0] next_ptr;
    logic [IDX_W-1:0] arb_ptr;
    logic [WIDTH-1:0] upper_req;
    logic [WIDTH-1:0] cand_req;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;

    // Owner index plus one, wrapping at the last requester.
    assign next_ptr = (idx_q == IDX_W'(WIDTH - 1)) ? '0 : idx_q + 1'b1;

    // The owner lets go on done, on dropping its request, or when its hold time runs out.
    assign release_w = (state_q == ST_OWNED) &&
                       (bus.done || !bus.req[idx_q] || hold_expired);

    // A releasing arbitration already uses the advanced pointer, so the old owner ranks last.
    assign arb_ptr = release_w ? next_ptr : ptr_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_upper
            assign upper_req[gi] = bus.req[gi] && (IDX_W'(gi) >= arb_ptr);
        end
    endgenerate

    // Lowest request at or above the pointer, otherwise lowest overall (wrap-around).
    always_comb begin
        cand_req  = (|upper_req) ? upper_req : bus.req;
        win_found = |bus.req;
        win_idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    // Next state and next grant.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_OWNED;
                    grant_d = ONE_HOT0 << win_idx;
                    idx_d   = win_idx;
                    valid_d = 1'b1;
                end
            end
            ST_OWNED: begin
                if (release_w) begin
                    ptr_d = next_ptr;
                    if (win_found) begin
                        grant_d = ONE_HOT0 << win_idx;
                        idx_d   = win_idx;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        idx_d   = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State, grant and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;

    // hold_q counts completed cycles of the current grant; TIMEOUT-1 means this is the last one.
    assign hold_expired = (hold_q == CNT_W'(TIMEOUT - 1));

    // Restart the count on every fresh grant; flag releases caused only by the limit.
    always_comb begin
        hold_d    = hold_q;
        timeout_d = 1'b0;
        if (state_q == ST_IDLE) begin
            hold_d = '0;
        end else if (release_w) begin
            hold_d    = '0;
            timeout_d = hold_expired && !bus.done && bus.req[idx_q];
        end else begin
            hold_d = hold_q + 1'b1;
        end
    end

    // Hold counter and timeout pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign bus.timeout  = 1'b0;
`endif

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
endmodule
